// File: rtl/ocm_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM; splits bursts into per-cycle RAM accesses.
// Optional OCM_BURST_ADAPTER_RD_BYPASS_EN: combinational read return (latency k+2 instead of k+3).
module ocm_burst_adapter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [BURST_W-1:0]    s_burstcount,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic                  s_busy,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  input  logic [DATA_W-1:0]     m_readdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST} state_t;

  state_t              state, state_nxt;
  logic [BURST_W-1:0]  remain, remain_nxt;
  logic [BURST_W-1:0]  bc_eff;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [BE_W-1:0]     be_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                cs_nxt;
  logic                wr_nxt;
  logic                rd_p1;

  assign bc_eff        = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
  assign s_waitrequest = (state == READ_BURST);

  // m_address doubles as the burst address counter: each beat is the previous one plus one.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    addr_nxt   = m_address;
    be_nxt     = m_byteenable;
    wdata_nxt  = m_writedata;
    cs_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (s_write) begin
          cs_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = s_address;
          be_nxt    = s_byteenable;
          wdata_nxt = s_writedata;
          if (bc_eff > BURST_W'(1)) begin
            state_nxt  = WRITE_BURST;
            remain_nxt = bc_eff - BURST_W'(1);
          end
        end else if (s_read) begin
          cs_nxt     = 1'b1;
          addr_nxt   = s_address;
          state_nxt  = READ_BURST;
          remain_nxt = bc_eff - BURST_W'(1);
        end
      end
      WRITE_BURST: begin
        if (s_write) begin
          cs_nxt     = 1'b1;
          wr_nxt     = 1'b1;
          addr_nxt   = m_address + ADDR_W'(1);
          be_nxt     = s_byteenable;
          wdata_nxt  = s_writedata;
          remain_nxt = remain - BURST_W'(1);
          if (remain == BURST_W'(1)) state_nxt = IDLE;
        end
      end
      READ_BURST: begin
        if (remain != '0) begin
          cs_nxt     = 1'b1;
          addr_nxt   = m_address + ADDR_W'(1);
          remain_nxt = remain - BURST_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remain       <= '0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_writedata  <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
    end else begin
      state        <= state_nxt;
      remain       <= remain_nxt;
      m_address    <= addr_nxt;
      m_byteenable <= be_nxt;
      m_writedata  <= wdata_nxt;
      m_chipselect <= cs_nxt;
      m_write      <= wr_nxt;
    end
  end

`ifdef OCM_BURST_ADAPTER_RD_BYPASS_EN
  // RAM data for a read issued last cycle is on m_readdata now.
  always_ff @(posedge clk) begin
    if (reset) rd_p1 <= 1'b0;
    else       rd_p1 <= m_chipselect & ~m_write;
  end

  assign s_readdata      = rd_p1 ? m_readdata : '0;
  assign s_readdatavalid = rd_p1;
  assign s_busy          = (state != IDLE) | rd_p1;
`else
  logic              rd_p2;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_p1   <= 1'b0;
      rd_p2   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_p1 <= m_chipselect & ~m_write;
      rd_p2 <= rd_p1;
      if (rd_p1) rdata_q <= m_readdata;
    end
  end

  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rd_p2;
  assign s_busy          = (state != IDLE) | rd_p1 | rd_p2;
`endif

endmodule

// File: tb/tb_ocm_burst_adapter.sv
// Scoreboard bench for ocm_burst_adapter with a behavioural 8192x32 byte-enabled RAM attached.
module tb_ocm_burst_adapter;

`ifdef OCM_BURST_ADAPTER_RD_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] s_address;
  logic [3:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        s_busy;
  logic [12:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  ocm_burst_adapter dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_busy(s_busy),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // RAM: address registered internally, read data unregistered.
  logic [31:0] mem [0:8191];
  logic [12:0] ram_ra = '0;
  always @(posedge clk) begin
    if (m_chipselect) begin
      if (m_write) mem[m_address] <= be_merge(mem[m_address], m_writedata, m_byteenable);
      ram_ra <= m_address;
    end
  end
  assign m_readdata = mem[ram_ra];

  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [12:0] addr; logic [31:0] data; logic [3:0] be; int cyc; } wr_exp_t;
  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  rd_exp_t     mon_r;
  wr_exp_t     mon_w;
  logic [31:0] ref_mem [0:8191];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          last_vld = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_chipselect && m_write) begin
        if (wq.size() == 0) check("ram_wr_unexpected", 32'd1, 32'd0);
        else begin
          mon_w = wq.pop_front();
          check("ram_wr_addr", 32'(m_address), 32'(mon_w.addr));
          check("ram_wr_data", m_writedata, mon_w.data);
          check("ram_wr_be", 32'(m_byteenable), 32'(mon_w.be));
          check("ram_wr_cycle", 32'(cyc), 32'(mon_w.cyc));
        end
      end
      if (s_readdatavalid) begin
        last_vld = cyc;
        if (rq.size() == 0) check("rd_vld_unexpected", 32'd1, 32'd0);
        else begin
          mon_r = rq.pop_front();
          check("rd_data", s_readdata, mon_r.data);
          check("rd_cycle", 32'(cyc), 32'(mon_r.cyc));
        end
      end
    end
  end

  task automatic chk_idle_outs();
    check("z_rdvalid", 32'(s_readdatavalid), 32'd0);
    check("z_rdata", s_readdata, 32'd0);
    check("z_busy", 32'(s_busy), 32'd0);
    check("z_wait", 32'(s_waitrequest), 32'd0);
    check("z_maddr", 32'(m_address), 32'd0);
    check("z_mbe", 32'(m_byteenable), 32'd0);
    check("z_mcs", 32'(m_chipselect), 32'd0);
    check("z_mwr", 32'(m_write), 32'd0);
    check("z_mwdata", m_writedata, 32'd0);
  endtask

  // Called at the start of a cycle; returns at the start of the next one.
  task automatic wr_beat(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [3:0] bc, input bit gap);
    s_write = 1'b1; s_address = a; s_writedata = d; s_byteenable = be; s_burstcount = bc;
    @(negedge clk);
    check("wr_wait", 32'(s_waitrequest), 32'd0);
    if (gap) check("wr_gap_cs", 32'(m_chipselect), 32'd0);
    wq.push_back('{a, d, be, cyc + 1});
    ref_mem[a] = be_merge(ref_mem[a], d, be);
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic rd_cmd(input logic [12:0] a, input logic [3:0] bc, output int acc);
    int          len;
    logic [12:0] ak;
    s_read = 1'b1; s_write = 1'b0; s_address = a; s_burstcount = bc;
    len = (bc == 4'd0) ? 1 : int'(bc);
    @(negedge clk);
    check("rd_accept_wait", 32'(s_waitrequest), 32'd0);
    acc = cyc;
    for (int k = 0; k < len; k++) begin
      ak = a + 13'(k);
      rq.push_back('{ref_mem[ak], acc + LAT + k});
    end
    @(posedge clk); #1;
    s_read = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check("rd_burst_wait", 32'(s_waitrequest), 32'd1);
    end
    @(negedge clk);
    check("rd_release_wait", 32'(s_waitrequest), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    check("drain_empty", 32'(rq.size() + wq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int fall;
    reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = '0;
    s_burstcount = '0; s_writedata = '0; s_byteenable = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_outs();
    @(posedge clk); #1;

    // single write then single read, then burstcount 0 behaving as 1
    wr_beat(13'h0010, 32'hDEADBEEF, 4'hF, 4'd1, 1'b0);
    @(posedge clk); #1;
    rd_cmd(13'h0010, 4'd1, acc);
    drain();
    wr_beat(13'h0400, 32'h0BADCAFE, 4'hF, 4'd0, 1'b0);
    rd_cmd(13'h0400, 4'd0, acc);
    drain();

    // wrapping write burst with one idle cycle after beat 1, then read it back
    wr_beat(13'h1FFE, 32'd1, 4'hF, 4'd4, 1'b0);
    wr_beat(13'h1FFF, 32'd2, 4'hF, 4'd4, 1'b0);
    @(posedge clk); #1;
    wr_beat(13'h0000, 32'd3, 4'hF, 4'd4, 1'b1);
    wr_beat(13'h0001, 32'd4, 4'hF, 4'd4, 1'b0);
    rd_cmd(13'h1FFE, 4'd4, acc);
    drain();

    // byte-enable merge: expect 0xFF34FF78
    wr_beat(13'h0200, 32'hFFFFFFFF, 4'hF, 4'd1, 1'b0);
    wr_beat(13'h0200, 32'h12345678, 4'b0101, 4'd1, 1'b0);
    rd_cmd(13'h0200, 4'd1, acc);
    drain();

    // read and write together in IDLE: write first, read re-presented next cycle
    s_read = 1'b1;
    wr_beat(13'h0300, 32'hCAFEF00D, 4'hF, 4'd1, 1'b0);
    rd_cmd(13'h0300, 4'd1, acc);
    drain();

    // reset in the second cycle of an 8-beat read burst
    s_read = 1'b1; s_address = 13'h0010; s_burstcount = 4'd8;
    @(negedge clk);
    check("rst_rd_accept", 32'(s_waitrequest), 32'd0);
    @(posedge clk); #1;
    s_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_vld", 32'(s_readdatavalid), 32'd0);
    end
    @(posedge clk); #1;
    rd_cmd(13'h0010, 4'd1, acc);
    drain();

    // read right after write to the same address; s_busy falls after the last valid
    wr_beat(13'h0100, 32'hA5A50100, 4'hF, 4'd1, 1'b0);
    rd_cmd(13'h0100, 4'd1, acc);
    fall = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!s_busy) begin
        fall = cyc;
        break;
      end
    end
    check("busy_fall_cycle", 32'(fall), 32'(acc + LAT + 1));
    check("busy_after_last_vld", 32'(fall), 32'(last_vld + 1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
